// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: datapath width, default reset vector,
// and the fetch queue entry layout.
// Pure definitions; no timing, no flow control.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One fetch slot: the PC is known when the request is issued, the
    // instruction word arrives later and sets filled.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            filled;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; low two bits are dropped.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order ring of fetch slots: allocated at request, filled at response, popped at head.
// Latency: a fill becomes visible at the head output one cycle after it is written.
// Backpressure: pop only when head is filled; alloc is refused when all slots are taken.
//
// Ports:
//   clk, rst_n             pipeline clock, synchronous active-low reset
//   flush                  synchronous clear of every slot and pointer
//   alloc, alloc_pc        reserve tail slot for a newly issued request
//   fill, fill_inst        write the oldest unfilled slot (ignored if none)
//   pop                    retire the head slot (ignored unless head is filled)
//   head_valid/pc/inst     head slot contents
//   occupancy              allocated slots, filled or not
//   unfilled               allocated slots still waiting for their response
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            alloc,
    input  logic [XLEN-1:0] alloc_pc,
    input  logic            fill,
    input  logic [XLEN-1:0] fill_inst,
    input  logic            pop,
    output logic            head_valid,
    output logic [XLEN-1:0] head_pc,
    output logic [XLEN-1:0] head_inst,
    output logic [CW-1:0]   occupancy,
    output logic [CW-1:0]   unfilled
);

    fetch_entry_t mem [DEPTH];

    // Pointers carry one extra wrap bit so that alloc-fill distinguishes
    // "all slots unfilled" from "none unfilled".
    logic [CW-1:0] alloc_ptr;
    logic [CW-1:0] fill_ptr;
    logic [CW-1:0] head_ptr;
    logic [CW-1:0] occ_q;

    logic alloc_fire;
    logic fill_fire;
    logic pop_fire;

    assign head_valid = mem[head_ptr[PW-1:0]].filled;
    assign head_pc    = mem[head_ptr[PW-1:0]].pc;
    assign head_inst  = mem[head_ptr[PW-1:0]].inst;
    assign occupancy  = occ_q;
    assign unfilled   = alloc_ptr - fill_ptr;

    assign alloc_fire = alloc && (occ_q != CW'(DEPTH));
    assign fill_fire  = fill && (unfilled != '0);
    assign pop_fire   = pop && head_valid;

    // Alloc, fill and pop always address distinct slots: alloc targets a
    // free slot, fill an allocated-unfilled one, pop a filled one.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            occ_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (alloc_fire) begin
                mem[alloc_ptr[PW-1:0]].pc     <= alloc_pc;
                mem[alloc_ptr[PW-1:0]].inst   <= '0;
                mem[alloc_ptr[PW-1:0]].filled <= 1'b0;
                alloc_ptr <= alloc_ptr + CW'(1);
            end
            if (fill_fire) begin
                mem[fill_ptr[PW-1:0]].inst   <= fill_inst;
                mem[fill_ptr[PW-1:0]].filled <= 1'b1;
                fill_ptr <= fill_ptr + CW'(1);
            end
            if (pop_fire) begin
                mem[head_ptr[PW-1:0]].filled <= 1'b0;
                head_ptr <= head_ptr + CW'(1);
            end
            occ_q <= occ_q + CW'(alloc_fire) - CW'(pop_fire);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues in-order imem requests, queues returned words for IF/ID.
// Latency: request -> response (>=1 cycle) -> if_valid the cycle after the response.
// Backpressure: if_ready low holds the head; requests stop once queued + dropped-in-flight reach DEPTH.
//
// Ports:
//   clk, rst_n                                   clock, synchronous active-low reset
//   imem_req_valid/ready, imem_req_addr          fetch request handshake
//   imem_rsp_valid, imem_rsp_data                in-order instruction return
//   redirect_valid, redirect_pc                  taken branch/jump from execute
//   if_valid/ready, if_pc, if_inst               head instruction to IF/ID
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_inst
);

    localparam int             CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]    DEPTH_W = (CW+1)'(DEPTH);

    logic [XLEN-1:0] pc;
    // Responses still owed by memory for requests that a redirect cancelled.
    logic [CW-1:0]   drop_cnt;

    logic [CW-1:0]   occupancy;
    logic [CW-1:0]   unfilled;
    logic            head_valid;
    logic [XLEN-1:0] head_pc;
    logic [XLEN-1:0] head_inst;

    logic [CW:0]     credit_used;
    logic [CW:0]     inflight;
    logic            req_ok;
    logic            req_fire;
    logic            rsp_live;
    logic            rsp_fill;

    // Dropped-but-outstanding responses still consume credit so that a
    // burst of redirects can never overrun the memory's in-flight limit.
    assign credit_used = {1'b0, occupancy} + {1'b0, drop_cnt};
    assign inflight    = {1'b0, unfilled}  + {1'b0, drop_cnt};

    assign req_ok   = rst_n && !redirect_valid && (credit_used < DEPTH_W);
    assign req_fire = req_ok && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_live = imem_rsp_valid && (inflight != '0);
    assign rsp_fill = rsp_live && (drop_cnt == '0) && !redirect_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight becomes a drop; a response arriving
            // right now retires one of them immediately.
            pc       <= word_align(redirect_pc);
            drop_cnt <= CW'(inflight - (CW+1)'(rsp_live));
        end else begin
            if (req_fire) begin
                pc <= pc + 32'd4;
            end
            if (rsp_live && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .alloc      (req_fire),
        .alloc_pc   (pc),
        .fill       (rsp_fill),
        .fill_inst  (imem_rsp_data),
        .pop        (if_ready && !redirect_valid),
        .head_valid (head_valid),
        .head_pc    (head_pc),
        .head_inst  (head_inst),
        .occupancy  (occupancy),
        .unfilled   (unfilled)
    );

    assign imem_req_valid = req_ok;
    assign imem_req_addr  = rst_n ? pc : '0;
    assign if_valid       = rst_n && head_valid;
    assign if_pc          = rst_n ? head_pc   : '0;
    assign if_inst        = rst_n ? head_inst : '0;

    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (inflight != '0));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-level reference model compared every cycle,
// an in-order memory stub with programmable latency, and directed scenarios.
module tb_fetch_stage;
    import riscv_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk            = 1'b0;
    logic        rst_n          = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = '0;
    logic        if_valid;
    logic        if_ready       = 1'b1;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    fetch_stage #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_inst        (if_inst)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] imem(input logic [31:0] a);
        return a ^ 32'hA5A5_0013;
    endfunction

    // Reference model: the queue as a list of {pc, inst, filled}, plus pc and drops owed.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          filled;
    } ment_t;
    ment_t       mq[$];
    logic [31:0] m_pc   = '0;
    int          m_drop = 0;

    // Memory stub: in-order responses, each no earlier than lat cycles after its request.
    typedef struct {
        logic [31:0] data;
        int          due;
    } mrsp_t;
    mrsp_t memq[$];
    int    lat      = 1;
    int    last_due = 0;
    int    cyc      = 0;

    logic [31:0] dl_pc[$];
    logic [31:0] dl_inst[$];
    logic [31:0] rq_addr[$];

    always @(posedge clk) begin
        #1;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memq[0].data;
            void'(memq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    logic        e_rv, e_iv, m_pop, m_hs;
    logic [31:0] e_addr;
    int          unf, fidx, due;
    ment_t       tmp;

    always @(negedge clk) begin
        e_rv   = rst_n && !redirect_valid && (mq.size() + m_drop < DEPTH);
        e_addr = rst_n ? m_pc : 32'h0;
        e_iv   = rst_n && mq.size() > 0 && mq[0].filled;
        chk("req_valid", 32'(imem_req_valid), 32'(e_rv));
        chk("req_addr", imem_req_addr, e_addr);
        chk("if_valid", 32'(if_valid), 32'(e_iv));
        if (e_iv) begin
            chk("if_pc", if_pc, mq[0].pc);
            chk("if_inst", if_inst, mq[0].inst);
        end else if (!rst_n) begin
            chk("if_pc_rst", if_pc, 32'h0);
            chk("if_inst_rst", if_inst, 32'h0);
        end

        if (imem_req_valid && imem_req_ready) begin
            rq_addr.push_back(imem_req_addr);
            due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            last_due = due;
            memq.push_back('{imem(imem_req_addr), due});
        end
        if (rst_n && !redirect_valid && if_valid && if_ready) begin
            dl_pc.push_back(if_pc);
            dl_inst.push_back(if_inst);
        end

        if (!rst_n) begin
            m_pc   = RPC;
            m_drop = 0;
            mq.delete();
            memq.delete();
            last_due = 0;
        end else if (redirect_valid) begin
            unf = 0;
            foreach (mq[i]) if (!mq[i].filled) unf++;
            m_drop = m_drop + unf - ((imem_rsp_valid && (m_drop + unf > 0)) ? 1 : 0);
            mq.delete();
            m_pc = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            m_pop = e_iv && if_ready;
            m_hs  = e_rv && imem_req_ready;
            if (imem_rsp_valid) begin
                if (m_drop > 0) begin
                    m_drop--;
                end else begin
                    fidx = -1;
                    foreach (mq[i]) if (fidx < 0 && !mq[i].filled) fidx = i;
                    if (fidx >= 0) begin
                        tmp = mq[fidx];
                        tmp.inst = imem_rsp_data;
                        tmp.filled = 1'b1;
                        mq[fidx] = tmp;
                    end
                end
            end
            if (m_pop) void'(mq.pop_front());
            if (m_hs) begin
                mq.push_back('{m_pc, 32'h0, 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        dl_pc.delete();
        dl_inst.delete();
        rq_addr.delete();
    endtask

    task automatic wait_deliv(input int n, input string name);
        int k = 0;
        while (dl_pc.size() < n && k < 200) begin
            tick();
            k++;
        end
        checks++;
        if (dl_pc.size() < n) begin
            failures++;
            $display("FAIL %s: timeout, delivered %0d needed %0d", name, dl_pc.size(), n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset, 1-cycle memory, IF/ID always ready.
        repeat (3) tick();
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_if_valid", 32'(if_valid), 32'h0);
        clear_logs();
        rst_n = 1'b1;
        #1;
        chk("rel_req_valid", 32'(imem_req_valid), 32'h1);
        chk("rel_req_addr", imem_req_addr, RPC);
        wait_deliv(4, "stream");
        chk("stream_pc0", dl_pc[0], 32'h0);
        chk("stream_pc1", dl_pc[1], 32'h4);
        chk("stream_pc2", dl_pc[2], 32'h8);
        chk("stream_pc3", dl_pc[3], 32'hC);
        chk("stream_inst0", dl_inst[0], 32'hA5A5_0013);
        chk("stream_inst3", dl_inst[3], 32'hA5A5_001F);

        // Stall: if_ready low, only DEPTH requests go out.
        rst_n = 1'b0;
        if_ready = 1'b0;
        tick();
        clear_logs();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("stall_nreq", 32'(rq_addr.size()), 32'd2);
        chk("stall_req_valid", 32'(imem_req_valid), 32'h0);
        chk("stall_if_valid", 32'(if_valid), 32'h1);
        chk("stall_if_pc", if_pc, 32'h0);
        tick();
        chk("stall_hold_pc", if_pc, 32'h0);
        chk("stall_hold_inst", if_inst, 32'hA5A5_0013);
        if_ready = 1'b1;
        wait_deliv(2, "stall_release");
        chk("stall_dl0", dl_pc[0], 32'h0);
        chk("stall_dl1", dl_pc[1], 32'h4);

        // 3-cycle memory, redirect with two requests outstanding.
        rst_n = 1'b0;
        lat = 3;
        tick();
        clear_logs();
        rst_n = 1'b1;
        tick();
        tick();
        chk("rd3_outstanding", 32'(rq_addr.size()), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        #1;
        chk("rd3_req_valid", 32'(imem_req_valid), 32'h0);
        tick();
        redirect_valid = 1'b0;
        wait_deliv(1, "rd3_deliver");
        chk("rd3_pc", dl_pc[0], 32'h100);
        chk("rd3_inst", dl_inst[0], 32'hA5A5_0113);
        chk("rd3_req_addr", rq_addr[2], 32'h100);

        // Redirect coinciding with a response and a pop.
        rst_n = 1'b0;
        lat = 1;
        tick();
        clear_logs();
        rst_n = 1'b1;
        tick();
        tick();
        chk("rdc_if_valid", 32'(if_valid), 32'h1);
        chk("rdc_rsp_valid", 32'(imem_rsp_valid), 32'h1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h203;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("rdc_req_valid", 32'(imem_req_valid), 32'h1);
        chk("rdc_req_addr", imem_req_addr, 32'h200);
        chk("rdc_pop_void", 32'(dl_pc.size()), 32'd0);
        wait_deliv(1, "rdc_deliver");
        chk("rdc_pc", dl_pc[0], 32'h200);

        // PC wrap at the top of the address space.
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        clear_logs();
        tick();
        redirect_valid = 1'b0;
        wait_deliv(2, "wrap_deliver");
        chk("wrap_req0", rq_addr[0], 32'hFFFF_FFFC);
        chk("wrap_req1", rq_addr[1], 32'h0);
        chk("wrap_pc0", dl_pc[0], 32'hFFFF_FFFC);
        chk("wrap_pc1", dl_pc[1], 32'h0);

        // One-cycle reset in the middle of a stream.
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("mrst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("mrst_req_addr", imem_req_addr, 32'h0);
        chk("mrst_if_valid", 32'(if_valid), 32'h0);
        chk("mrst_if_pc", if_pc, 32'h0);
        chk("mrst_if_inst", if_inst, 32'h0);
        tick();
        rst_n = 1'b1;
        clear_logs();
        #1;
        chk("mrst_rel_valid", 32'(imem_req_valid), 32'h1);
        chk("mrst_rel_addr", imem_req_addr, RPC);
        chk("mrst_rel_if_valid", 32'(if_valid), 32'h0);
        wait_deliv(1, "mrst_deliver");
        chk("mrst_pc", dl_pc[0], RPC);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
